// File: rtl/jtvigil_pkg.sv
// Shared types and constants for the Vigilante sound-ROM slot arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jtvigil_pkg;

  localparam int ROM_AW = 17;

  // Program ROM occupies 0..FFFF, so PCM samples sit directly above it.
  localparam logic [ROM_AW-1:0] PCM_OFFSET_DEF = 17'h1_0000;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  // Plain 17-bit unsigned add; the offset is chosen so offset+FFFF never wraps.
  function automatic logic [ROM_AW-1:0] rom_offset_add(input logic [ROM_AW-1:0] off,
                                                      input logic [15:0]       addr);
    return off + {1'b0, addr};
  endfunction

endpackage

// File: rtl/jtvigil_rom_cache.sv
// One-entry tag/data cache in front of a ROM requester; hit and ok are combinational.
// Latency: a fill becomes visible as ok on the cycle after the fill strobe.
// Backpressure: none; pending stays high until a fill for the current address lands.
module jtvigil_rom_cache
  import jtvigil_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic [15:0] addr,
  input  logic        fill,
  input  logic [15:0] fill_tag,
  input  logic [7:0]  fill_data,
  output logic        ok,
  output logic        pending,
  output logic [7:0]  data
);

  logic        valid;
  logic [15:0] tag;
  logic        hit;

  assign hit     = valid && (tag == addr);
  assign ok      = cs && hit;
  assign pending = cs && !hit;

  // Capture the completed access; the tag is the address that was issued, not the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      data  <= fill_data;
    end
  end

endmodule

// File: rtl/jtvigil_sndrom_arb.sv
// Shares one SDRAM ROM slot between the sound Z80 fetch and the PCM sample fetch.
// Latency: grant -> OK_DLY masked cycles -> first accepted rom_ok -> ok on the next cycle.
// Backpressure: one access in flight; PCM wins unless the CPU has lost PCM_BURST grants in a row.
module jtvigil_sndrom_arb
  import jtvigil_pkg::*;
#(
  parameter logic [ROM_AW-1:0] PCM_OFFSET = PCM_OFFSET_DEF,
  parameter int                OK_DLY     = 1,
  parameter int                PCM_BURST  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_cs,
  input  logic [15:0]       cpu_addr,
  output logic [7:0]        cpu_data,
  output logic              cpu_ok,
  input  logic              pcm_cs,
  input  logic [15:0]       pcm_addr,
  output logic [7:0]        pcm_data,
  output logic              pcm_ok,
  output logic              rom_cs,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              rom_ok
);

  localparam int MW = $clog2(OK_DLY + 2);
  localparam int BW = $clog2(PCM_BURST + 2);
  localparam logic [MW-1:0] MASK_LOAD = MW'(OK_DLY);
  localparam logic [BW-1:0] BURST_MAX = BW'(PCM_BURST);

  arb_state_t     state, state_nx;
  logic [MW-1:0]  mask_cnt;
  logic [BW-1:0]  burst;
  logic           win_pcm;
  logic [15:0]    win_tag;
  logic           cpu_pend, pcm_pend;
  logic           grant_cpu, grant_pcm, done;
  logic           cpu_fill, pcm_fill;

  assign cpu_fill = done && !win_pcm;
  assign pcm_fill = done &&  win_pcm;

  jtvigil_rom_cache u_cpu_cache (
    .clk       (clk),
    .rst       (rst),
    .cs        (cpu_cs),
    .addr      (cpu_addr),
    .fill      (cpu_fill),
    .fill_tag  (win_tag),
    .fill_data (rom_data),
    .ok        (cpu_ok),
    .pending   (cpu_pend),
    .data      (cpu_data)
  );

  jtvigil_rom_cache u_pcm_cache (
    .clk       (clk),
    .rst       (rst),
    .cs        (pcm_cs),
    .addr      (pcm_addr),
    .fill      (pcm_fill),
    .fill_tag  (win_tag),
    .fill_data (rom_data),
    .ok        (pcm_ok),
    .pending   (pcm_pend),
    .data      (pcm_data)
  );

  // Arbitration and completion decode; nothing is granted in the cycle a fill is written.
  always_comb begin
    state_nx  = state;
    grant_cpu = 1'b0;
    grant_pcm = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (pcm_pend && !(cpu_pend && burst == BURST_MAX)) begin
          grant_pcm = 1'b1;
          state_nx  = WAIT;
        end else if (cpu_pend) begin
          grant_cpu = 1'b1;
          state_nx  = WAIT;
        end
      end
      WAIT: begin
        if (mask_cnt == '0 && rom_ok) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Issue the winning address, latch who owns it, and run the stale-ok mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      win_pcm  <= 1'b0;
      win_tag  <= '0;
      mask_cnt <= '0;
    end else if (grant_pcm || grant_cpu) begin
      rom_cs   <= 1'b1;
      rom_addr <= grant_pcm ? rom_offset_add(PCM_OFFSET, pcm_addr) : {1'b0, cpu_addr};
      win_pcm  <= grant_pcm;
      win_tag  <= grant_pcm ? pcm_addr : cpu_addr;
      mask_cnt <= MASK_LOAD;
    end else if (state == WAIT) begin
      if (mask_cnt != '0) mask_cnt <= mask_cnt - MW'(1);
      if (done)           rom_cs   <= 1'b0;
    end
  end

  // Count PCM grants that jumped a waiting CPU; any CPU grant or idle CPU resets the streak.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst <= '0;
    end else if (!cpu_pend || grant_cpu) begin
      burst <= '0;
    end else if (grant_pcm && burst != BURST_MAX) begin
      burst <= burst + BW'(1);
    end
  end

endmodule

// File: tb/tb_jtvigil_sndrom_arb.sv
// Directed bench for the sound-ROM arbiter with a small SDRAM slot model.
// Latency: model answers LAT cycles after a new address, optionally holding a stale ok.
// Backpressure: every wait is bounded by a cycle budget.
module tb_jtvigil_sndrom_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_cs = 1'b0, pcm_cs = 1'b0;
  logic [15:0] cpu_addr = '0, pcm_addr = '0;
  logic [7:0]  cpu_data, pcm_data;
  logic        cpu_ok, pcm_ok;
  logic        rom_cs;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic        rom_ok = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // ROM model state
  int          lat        = 3;
  bit          stale_mode = 1'b0;
  int          mcnt       = 0;
  logic [16:0] last_addr  = '0;
  logic        last_cs    = 1'b0;

  localparam int S_ROMCS = 0;
  localparam int S_CPUOK = 1;
  localparam int S_PCMOK = 2;

  logic [16:0] exp_addr [6] = '{17'h10100, 17'h10101, 17'h04000,
                                17'h10102, 17'h10103, 17'h04001};

  jtvigil_sndrom_arb dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_cs   (cpu_cs),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_ok   (cpu_ok),
    .pcm_cs   (pcm_cs),
    .pcm_addr (pcm_addr),
    .pcm_data (pcm_data),
    .pcm_ok   (pcm_ok),
    .rom_cs   (rom_cs),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_ok   (rom_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {a[16], 7'h7C};
  endfunction

  // SDRAM slot model: data valid LAT cycles after a new address; stale mode keeps the old ok/data.
  always @(negedge clk) begin
    if (!rom_cs) begin
      mcnt = 0;
      if (!stale_mode) rom_ok = 1'b0;
    end else if (!last_cs || rom_addr != last_addr) begin
      mcnt = 0;
      if (!stale_mode) rom_ok = 1'b0;
    end else begin
      mcnt = mcnt + 1;
      if (mcnt >= lat) begin
        rom_ok   = 1'b1;
        rom_data = rom_fn(rom_addr);
      end
    end
    last_addr = rom_addr;
    last_cs   = rom_cs;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic cur(input int sel);
    case (sel)
      S_ROMCS: return rom_cs;
      S_CPUOK: return cpu_ok;
      default: return pcm_ok;
    endcase
  endfunction

  // Step negedges until the selected output equals v; an expired budget is a failed check.
  task automatic wait_sig(input int sel, input logic v, input string tag, output int n);
    n = 0;
    while (cur(sel) !== v && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (cur(sel) !== v) chk({tag, "_timeout"}, 32'(cur(sel)), 32'(v));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hits;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rom_cs",   32'(rom_cs),   32'h0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rom_cs",  32'(rom_cs),   32'h0);
    chk("rst_cpu_data", 32'(cpu_data), 32'h0);
    chk("rst_pcm_data", 32'(pcm_data), 32'h0);
    chk("rst_cpu_ok",   32'(cpu_ok),   32'h0);
    chk("rst_pcm_ok",   32'(pcm_ok),   32'h0);

    // 1. CPU only
    cpu_cs = 1'b1; cpu_addr = 16'h1234;
    #1 chk("t1_ok_miss", 32'(cpu_ok), 32'h0);
    wait_sig(S_ROMCS, 1'b1, "t1_grant", n);
    chk("t1_rom_addr", 32'(rom_addr), 32'h01234);
    wait_sig(S_CPUOK, 1'b1, "t1_ok", n);
    chk("t1_latency", 32'(n), 32'd4);
    chk("t1_data", 32'(cpu_data), 32'h5A);
    hits = 0;
    repeat (6) begin
      @(negedge clk);
      if (rom_cs) hits++;
    end
    chk("t1_no_reissue", 32'(hits), 32'h0);
    chk("t1_ok_hold", 32'(cpu_ok), 32'h1);

    // 2. PCM only, then address step
    cpu_cs = 1'b0;
    pcm_cs = 1'b1; pcm_addr = 16'h0010;
    wait_sig(S_ROMCS, 1'b1, "t2_grant", n);
    chk("t2_rom_addr", 32'(rom_addr), 32'h10010);
    wait_sig(S_PCMOK, 1'b1, "t2_ok", n);
    chk("t2_data", 32'(pcm_data), 32'hEC);
    pcm_addr = 16'h0011;
    #1 chk("t2_ok_drop", 32'(pcm_ok), 32'h0);
    wait_sig(S_ROMCS, 1'b1, "t2_regrant", n);
    chk("t2_rom_addr2", 32'(rom_addr), 32'h10011);
    wait_sig(S_PCMOK, 1'b1, "t2_ok2", n);
    chk("t2_data2", 32'(pcm_data), 32'hED);

    // 3. Both pending, PCM advances after every access
    @(negedge clk);
    pcm_addr = 16'h0100;
    cpu_cs = 1'b1; cpu_addr = 16'h4000;
    for (int g = 0; g < 6; g++) begin
      wait_sig(S_ROMCS, 1'b1, "t3_grant", n);
      chk($sformatf("t3_order%0d", g), 32'(rom_addr), 32'(exp_addr[g]));
      wait_sig(S_ROMCS, 1'b0, "t3_done", n);
      if (rom_addr[16]) pcm_addr = pcm_addr + 16'h1;
      else              cpu_addr = cpu_addr + 16'h1;
    end
    cpu_cs = 1'b0;
    pcm_cs = 1'b0;
    repeat (2) @(negedge clk);

    // 4. Stale rom_ok held across the address change
    stale_mode = 1'b1; lat = 1;
    pcm_cs = 1'b1; pcm_addr = 16'h0020;
    wait_sig(S_PCMOK, 1'b1, "t4_ok", n);
    chk("t4_data", 32'(pcm_data), 32'hDC);
    chk("t4_stale_level", 32'(rom_ok), 32'h1);
    pcm_addr = 16'h0021;
    wait_sig(S_ROMCS, 1'b1, "t4_grant", n);
    chk("t4_rom_addr", 32'(rom_addr), 32'h10021);
    wait_sig(S_PCMOK, 1'b1, "t4_ok2", n);
    chk("t4_new_data", 32'(pcm_data), 32'hDD);
    stale_mode = 1'b0; lat = 3;
    repeat (2) @(negedge clk);

    // 5. CPU address moves while its access is in flight
    cpu_cs = 1'b1; cpu_addr = 16'h2000;
    wait_sig(S_ROMCS, 1'b1, "t5_grant", n);
    chk("t5_rom_addr", 32'(rom_addr), 32'h02000);
    cpu_addr = 16'h2001;
    wait_sig(S_ROMCS, 1'b0, "t5_done", n);
    chk("t5_ok_old_tag", 32'(cpu_ok), 32'h0);
    chk("t5_data_old", 32'(cpu_data), 32'h5C);
    wait_sig(S_ROMCS, 1'b1, "t5_regrant", n);
    chk("t5_rom_addr2", 32'(rom_addr), 32'h02001);
    wait_sig(S_CPUOK, 1'b1, "t5_ok", n);
    chk("t5_data_new", 32'(cpu_data), 32'h5D);

    // 6. Reset while waiting on the ROM
    chk("t6_pcm_ok_pre", 32'(pcm_ok), 32'h1);
    cpu_addr = 16'h3000;
    wait_sig(S_ROMCS, 1'b1, "t6_grant", n);
    chk("t6_rom_addr", 32'(rom_addr), 32'h03000);
    #2 rst = 1'b1;
    #1;
    chk("t6_rom_cs_async", 32'(rom_cs), 32'h0);
    chk("t6_cpu_ok", 32'(cpu_ok), 32'h0);
    chk("t6_pcm_ok", 32'(pcm_ok), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_sig(S_ROMCS, 1'b1, "t6_refetch", n);
    chk("t6_refetch_addr", 32'(rom_addr), 32'h10021);
    wait_sig(S_PCMOK, 1'b1, "t6_pcm_ok2", n);
    chk("t6_pcm_data", 32'(pcm_data), 32'hDD);
    wait_sig(S_ROMCS, 1'b1, "t6_cpu_grant", n);
    chk("t6_cpu_addr", 32'(rom_addr), 32'h03000);
    wait_sig(S_CPUOK, 1'b1, "t6_cpu_ok2", n);
    chk("t6_cpu_data", 32'(cpu_data), 32'h4C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
